pc_sched: RTL
=============

PC_SCHED -- requirements
Module: pc_sched

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous reset, active-high.
- stall_i  in  1  pipeline stall; hold current PC.
- br_valid_i  in  1  branch redirect request.
- br_target_i  in  32  branch target address.
- exc_valid_i  in  1  exception redirect request.
- exc_target_i  in  32  exception vector address.
- imem_ack_i  in  1  instruction memory accepted fetch at pc_o.
- pc_o  out  32  current fetch address.
- ce_o  out  1  fetch chip enable; 1 = fetch active.
- imem_req_o  out  1  fetch request; high only in FETCH.
- flush_o  out  1  one-cycle pulse; younger pipeline contents are invalid.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-004 The FSM SHALL go IDLE -> FETCH on the first clk edge after rst deasserts; ce_o SHALL go to 1 on that edge and pc_o SHALL stay 0x00000000.
REQ-005 Outputs SHALL be decoded from state as: imem_req_o = (state == FETCH); ce_o = (state != IDLE).
REQ-006 In FETCH, on imem_ack_i=1 and stall_i=0, pc_o SHALL load next-PC and the state SHALL remain FETCH.
REQ-007 In FETCH, on imem_ack_i=1 and stall_i=1, pc_o SHALL hold and the state SHALL go to HOLD.
REQ-008 In FETCH, while imem_ack_i=0, pc_o SHALL hold, regardless of stall_i.
REQ-009 In HOLD, when stall_i=0, pc_o SHALL load next-PC and the state SHALL go to FETCH; while stall_i=1 the state SHALL remain HOLD.
REQ-010 Next-PC priority SHALL be: exception (input or pending) > branch (input or pending) > pc_o + 4.
REQ-011 pc_o + 4 SHALL be 32-bit modulo: 0xFFFFFFFC -> 0x00000000.
REQ-012 Redirect targets SHALL be loaded with bits [1:0] forced to 0.
REQ-013 A redirect sampled in FETCH or HOLD that is not consumed on the same edge SHALL be latched into a pending register, with a valid flag and a type flag.
REQ-014 Pending-register write rules:
- An exception SHALL overwrite a pending branch.
- A branch SHALL NOT overwrite a pending exception.
- A newer branch SHALL overwrite an older pending branch.
REQ-015 Pending SHALL clear on the edge where next-PC is loaded.
REQ-016 When exc_valid_i and br_valid_i are high together, the exception SHALL win and the branch SHALL be dropped.
REQ-017 flush_o SHALL be registered and SHALL be high for exactly the one cycle after any edge on which a redirect is sampled in FETCH or HOLD.
REQ-018 In IDLE, imem_ack_i, br_valid_i and exc_valid_i SHALL be ignored.

Reset
REQ-019 While rst=1, independent of clk, the block SHALL force:
- pc_o = 0x00000000, ce_o = 0, imem_req_o = 0, flush_o = 0.
- state = IDLE.
- pending valid flag = 0.
REQ-020 Reset asserted mid-fetch SHALL abandon the outstanding fetch; an ack arriving after reset SHALL have no effect.

Configuration
REQ-021 With macro EXC_REDIRECT_EN defined, exception redirects SHALL behave as in REQ-010 to REQ-016.
REQ-022 Without EXC_REDIRECT_EN:
- exc_valid_i and exc_target_i SHALL be ignored.
- No exception pending state SHALL be built.
- Only branch and sequential next-PC SHALL exist.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Release rst, ack every cycle, no stall -> ce_o=1 one edge after release; pc_o sequence 0x0, 0x4, 0x8, 0xC.
- Set pc_o=0xFFFFFFFC, ack -> pc_o=0x00000000.
- br_valid_i=1, br_target_i=0x00400013, ack same cycle -> pc_o=0x00400010; flush_o high exactly one cycle.
- br_valid_i pulse with no ack, then exc_valid_i pulse (exc_target_i=0x80000180), then ack -> pc_o=0x80000180.
- Ack with stall_i=1 for 3 cycles -> HOLD, imem_req_o=0, pc_o held; on stall release pc_o += 4 and imem_req_o=1.
- rst pulsed mid-fetch at pc_o=0x20, ack one cycle later -> pc_o=0x0 and state IDLE; FETCH resumes from 0x0.

Source files
------------

// File: rtl/pc_sched.sv
// pc_sched: fetch-address scheduler.
//
// Sequences the instruction fetch address through IDLE -> FETCH <-> HOLD. The PC advances by 4
// on an accepted, unstalled fetch, or jumps to a redirect target. Redirects that arrive while
// the PC cannot move are kept in a single pending slot until the next PC load.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   stall_i            pipeline stall, PC holds
//   br_valid_i/target  branch redirect request and target
//   exc_valid_i/target exception redirect request and vector
//   imem_ack_i         instruction memory accepted the fetch at pc_o
//   pc_o               current fetch address
//   ce_o               fetch chip enable (state != IDLE)
//   imem_req_o         fetch request (state == FETCH)
//   flush_o            one-cycle pulse after a redirect was sampled
//
// Configuration:
//   EXC_REDIRECT_EN    when defined, exception redirects and the pending exception flag are
//                      built; otherwise exc_valid_i/exc_target_i are ignored.
module pc_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_valid_i,
  input  logic [31:0] exc_target_i,
  input  logic        imem_ack_i,
  output logic [31:0] pc_o,
  output logic        ce_o,
  output logic        imem_req_o,
  output logic        flush_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFetch = 2'd1;
  localparam logic [1:0] StHold  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        exc_req;
  logic [31:0] exc_tgt;
  logic        pend_exc;
  logic        active;
  logic        advance;
  logic        latch_exc;
  logic        latch_br;
  logic [31:0] br_tgt;
  logic [31:0] next_pc;

`ifdef EXC_REDIRECT_EN
  logic pend_exc_q, pend_exc_d;

  assign exc_req  = exc_valid_i;
  assign exc_tgt  = {exc_target_i[31:2], 2'b00};
  assign pend_exc = pend_exc_q;

  // Type flag: set by a latched exception, cleared by a latched branch or a PC load.
  always_comb begin
    pend_exc_d = pend_exc_q;
    if (advance) begin
      pend_exc_d = 1'b0;
    end else if (latch_exc) begin
      pend_exc_d = 1'b1;
    end else if (latch_br) begin
      pend_exc_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_exc_q <= 1'b0;
    end else begin
      pend_exc_q <= pend_exc_d;
    end
  end
`else
  logic unused_exc;

  assign exc_req    = 1'b0;
  assign exc_tgt    = '0;
  assign pend_exc   = 1'b0;
  assign unused_exc = ^{exc_valid_i, exc_target_i};
`endif

  assign br_tgt = {br_target_i[31:2], 2'b00};
  assign active = (state_q != StIdle);

  // PC loads on an accepted unstalled fetch, or when a held fetch is released.
  assign advance = ((state_q == StFetch) && imem_ack_i && !stall_i) ||
                   ((state_q == StHold) && !stall_i);

  // A pending exception beats a fresh branch; a fresh branch replaces a pending branch.
  always_comb begin
    next_pc = pc_q + 32'd4;
    if (exc_req) begin
      next_pc = exc_tgt;
    end else if (pend_valid_q && pend_exc) begin
      next_pc = pend_target_q;
    end else if (br_valid_i) begin
      next_pc = br_tgt;
    end else if (pend_valid_q) begin
      next_pc = pend_target_q;
    end
  end

  assign latch_exc = active && !advance && exc_req;
  assign latch_br  = active && !advance && br_valid_i && !exc_req && !(pend_valid_q && pend_exc);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    flush_d       = active && (br_valid_i || exc_req);

    case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: if (imem_ack_i && stall_i) state_d = StHold;
      StHold:  if (!stall_i) state_d = StFetch;
      default: state_d = StIdle;
    endcase

    if (advance) begin
      pc_d         = next_pc;
      pend_valid_d = 1'b0;
    end else if (latch_exc) begin
      pend_valid_d  = 1'b1;
      pend_target_d = exc_tgt;
    end else if (latch_br) begin
      pend_valid_d  = 1'b1;
      pend_target_d = br_tgt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      pc_q          <= '0;
      flush_q       <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      flush_q       <= flush_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = (state_q != StIdle);
  assign imem_req_o = (state_q == StFetch);
  assign flush_o    = flush_q;

endmodule
